// File: rtl/prim_ram_1p_rmw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prim_ram_1p_rmw                                                |
// | Purpose  : Partial-write host port in front of a full-word-only ECC RAM,   |
// |            using read-modify-write for masked writes.                     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module prim_ram_1p_rmw #(
  parameter int Depth = 512,
  parameter int Width = 32,
  localparam int Aw   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             req_i,
  output logic             gnt_o,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,

  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       rerror_o,

  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,

  input  logic             ram_rvalid_i,
  input  logic [Width-1:0] ram_rdata_i,
  input  logic [1:0]       ram_rerror_i,

  output logic             rmw_err_o,
  output logic [7:0]       err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RMW_RD  = 2'd2,
    ST_RMW_WR  = 2'd3
  } state_e;

  localparam logic [7:0] c_cnt_max = 8'hFF;

  state_e             r_state;
  logic [Aw-1:0]      r_addr;
  logic [Width-1:0]   r_wdata;
  logic [Width-1:0]   r_wmask;
  logic [Width-1:0]   r_merged;
  logic               r_rmw_err;
  logic [7:0]         r_err_cnt;

  logic               w_full_mask;
  logic               w_accept;
  logic               w_uncorr;

  assign w_full_mask = &wmask_i;
  // Requests are refused while reset is held so nothing reaches the RAM.
  assign w_accept    = (r_state == ST_IDLE) && req_i && !rst_i;
  assign w_uncorr    = ram_rvalid_i && ram_rerror_i[1] &&
                       ((r_state == ST_RD_WAIT) || (r_state == ST_RMW_RD));

  assign gnt_o       = (r_state == ST_IDLE) && !rst_i;
  assign ram_wmask_o = {Width{1'b1}};
  assign rmw_err_o   = r_rmw_err;
  assign err_cnt_o   = r_err_cnt;

  always_comb begin
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    rvalid_o    = 1'b0;
    rdata_o     = '0;
    rerror_o    = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          ram_req_o  = 1'b1;
          ram_addr_o = addr_i;
          if (write_i && w_full_mask) begin
            ram_write_o = 1'b1;
            ram_wdata_o = wdata_i;
          end
        end
      end
      ST_RD_WAIT: begin
        if (ram_rvalid_i) begin
          rvalid_o = 1'b1;
          rdata_o  = ram_rdata_i;
          rerror_o = ram_rerror_i;
        end
      end
      ST_RMW_WR: begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = r_addr;
        ram_wdata_o = r_merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_merged  <= '0;
      r_rmw_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_rmw_err <= 1'b0;
      if (w_uncorr && (r_err_cnt != c_cnt_max)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!write_i) begin
              r_state <= ST_RD_WAIT;
            end else if (!w_full_mask) begin
              r_addr  <= addr_i;
              r_wdata <= wdata_i;
              r_wmask <= wmask_i;
              r_state <= ST_RMW_RD;
            end
          end
        end
        ST_RD_WAIT: begin
          if (ram_rvalid_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RMW_RD: begin
          if (ram_rvalid_i) begin
            // An uncorrectable word must not be written back with a fresh ECC.
            if (ram_rerror_i[1]) begin
              r_rmw_err <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_merged <= (r_wdata & r_wmask) | (ram_rdata_i & ~r_wmask);
              r_state  <= ST_RMW_WR;
            end
          end
        end
        ST_RMW_WR: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
